reg_file_dump: RTL and testbench

Register file for the single-cycle ARM datapath: it consumes the register selects produced by the instruction-field select logic (ReadSelect1, ReadSelect2, WriteSelect) and returns the two operand buses. It commits write-back data on the clock edge. It also provides a sequential debug dump port that streams all 32 registers out over a valid/ready handshake, so the bench and the board can snapshot architectural state.

---
 rtl/reg_file_dump.sv | 131 +++++++++++++
 tb/tb_reg_file_dump.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump.sv
// reg_file_dump
//   Register file for the single-cycle ARM datapath: 32 x DATA_W registers with
//   two combinational read ports, one write port, and a write-through bypass.
//   Index 31 is XZR: it always reads as zero, and writes to it are dropped.
//   A debug dump port streams all 32 registers, in index order, over a
//   valid/ready handshake. Each beat's data is snapshotted on the edge that
//   loads it, and is held while the beat is stalled.
//
// Ports
//   Clk          in   sole clock, rising edge
//   Reset_n      in   synchronous active-low reset (storage and dump FSM)
//   ReadSelect1  in   read port 1 index
//   ReadSelect2  in   read port 2 index
//   WriteSelect  in   write port index
//   RegWrite     in   write enable
//   WriteData    in   write-back data
//   ReadData1    out  read port 1 data (combinational)
//   ReadData2    out  read port 2 data (combinational)
//   DumpReq      in   start-dump request, level sampled in IDLE
//   DumpReady    in   consumer accepts the current dump beat
//   DumpValid    out  dump beat valid (registered)
//   DumpIndex    out  register index of the current beat (registered)
//   DumpData     out  snapshot value of the current beat (registered)
//   DumpBusy     out  high while the dump FSM is in SEND
module reg_file_dump #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [4:0]        ReadSelect1,
    input  logic [4:0]        ReadSelect2,
    input  logic [4:0]        WriteSelect,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              DumpReq,
    input  logic              DumpReady,
    output logic              DumpValid,
    output logic [4:0]        DumpIndex,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpBusy
);

    localparam logic [4:0] XZR      = 5'd31;
    localparam logic [4:0] LAST_IDX = 5'd31;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    dump_state_t       state;
    logic [4:0]        next_index;

    // The architectural view of register `sel` on this edge: XZR is zero, and
    // a write committing on the same edge wins over storage. The read ports
    // and the dump snapshot share this definition.
    function automatic logic [DATA_W-1:0] view_reg(
        input logic [4:0]        sel,
        input logic              we,
        input logic [4:0]        wsel,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (sel == XZR)
            return '0;
        else if (we && (wsel == sel))
            return wdata;
        else
            return stored;
    endfunction

    assign ReadData1  = view_reg(ReadSelect1, RegWrite, WriteSelect, WriteData, regs[ReadSelect1]);
    assign ReadData2  = view_reg(ReadSelect2, RegWrite, WriteSelect, WriteData, regs[ReadSelect2]);
    assign next_index = DumpIndex + 5'd1;
    assign DumpBusy   = (state == SEND);

    // Storage
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (RegWrite && (WriteSelect != XZR)) begin
            regs[WriteSelect] <= WriteData;
        end
    end

    // Dump FSM. DumpIndex and DumpData change only on a load edge, so a
    // stalled beat keeps its snapshot even if that register is rewritten.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            DumpValid <= 1'b0;
            DumpIndex <= '0;
            DumpData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (DumpReq) begin
                        state     <= SEND;
                        DumpValid <= 1'b1;
                        DumpIndex <= '0;
                        DumpData  <= view_reg(5'd0, RegWrite, WriteSelect, WriteData, regs[0]);
                    end
                end
                SEND: begin
                    // DumpValid is always high in SEND, so DumpReady alone
                    // marks an accepted beat. DumpReq is ignored here.
                    if (DumpReady) begin
                        if (DumpIndex == LAST_IDX) begin
                            state     <= IDLE;
                            DumpValid <= 1'b0;
                        end else begin
                            DumpIndex <= next_index;
                            DumpData  <= view_reg(next_index, RegWrite, WriteSelect,
                                                  WriteData, regs[next_index]);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    DumpValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dump.sv
// tb_reg_file_dump
//   Self-checking bench for reg_file_dump. Expected dump beats are pushed to a
//   scoreboard queue when a dump is requested. A negedge monitor pops one entry
//   per accepted beat and compares its index and data. Read-port, reset and
//   handshake checks are made directly from the main sequence.
module tb_reg_file_dump;

    localparam int DATA_W = 64;

    logic              Clk;
    logic              Reset_n;
    logic [4:0]        ReadSelect1;
    logic [4:0]        ReadSelect2;
    logic [4:0]        WriteSelect;
    logic              RegWrite;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              DumpReq;
    logic              DumpReady;
    logic              DumpValid;
    logic [4:0]        DumpIndex;
    logic [DATA_W-1:0] DumpData;
    logic              DumpBusy;

    reg_file_dump #(.DATA_W(DATA_W), .NUM_REGS(32)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .ReadSelect1 (ReadSelect1),
        .ReadSelect2 (ReadSelect2),
        .WriteSelect (WriteSelect),
        .RegWrite    (RegWrite),
        .WriteData   (WriteData),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .DumpReq     (DumpReq),
        .DumpReady   (DumpReady),
        .DumpValid   (DumpValid),
        .DumpIndex   (DumpIndex),
        .DumpData    (DumpData),
        .DumpBusy    (DumpBusy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]        idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             sb [$];
    logic [DATA_W-1:0] mregs [32];
    logic [DATA_W-1:0] exp_beats [32];
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accepted beat per negedge where valid and ready are both high.
    always @(negedge Clk) begin
        if (Reset_n && DumpValid && DumpReady) begin
            if (sb.size() == 0) begin
                check("extra_beat_queue_size", 64'(sb.size()), 64'd1);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("dump_idx", 64'(DumpIndex), 64'(e.idx));
                check("dump_data", DumpData, e.data);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [DATA_W-1:0] d);
        RegWrite    = 1'b1;
        WriteSelect = 5'(sel);
        WriteData   = d;
        step();
        RegWrite = 1'b0;
        if (sel != 31) mregs[sel] = d;
    endtask

    // Snapshot the model into exp_beats; a test may then override entries.
    task automatic load_exp_from_model();
        for (int i = 0; i < 32; i++)
            exp_beats[i] = (i == 31) ? '0 : mregs[i];
    endtask

    task automatic push_exp();
        for (int i = 0; i < 32; i++)
            sb.push_back('{idx: 5'(i), data: exp_beats[i]});
    endtask

    task automatic pulse_req();
        DumpReq = 1'b1;
        step();
        DumpReq = 1'b0;
    endtask

    task automatic wait_index(input logic [4:0] target, input string tag);
        for (int c = 0; c < 200; c++) begin
            if (DumpValid && DumpIndex == target) break;
            step();
        end
        check(tag, 64'(DumpValid && DumpIndex == target), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 1000; c++) begin
            if (!DumpBusy) break;
            step();
        end
        check(tag, 64'(DumpBusy), 64'd0);
        check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            ReadSelect1 = 5'(i);
            ReadSelect2 = 5'(31 - i);
            #1;
            check(tag, ReadData1, (i == 31) ? '0 : mregs[i]);
            check(tag, ReadData2, (i == 0) ? '0 : mregs[31 - i]);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;

        Reset_n     = 1'b0;
        ReadSelect1 = '0;
        ReadSelect2 = '0;
        WriteSelect = '0;
        RegWrite    = 1'b0;
        WriteData   = '0;
        DumpReq     = 1'b0;
        DumpReady   = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        // Reset, write, read
        step();
        step();
        check("rst_valid", 64'(DumpValid), 64'd0);
        check("rst_index", 64'(DumpIndex), 64'd0);
        check("rst_data", DumpData, 64'd0);
        check("rst_busy", 64'(DumpBusy), 64'd0);
        Reset_n = 1'b1;
        step();
        wr(5, 64'h1122334455667788);
        wr(31, 64'hFFFF);
        ReadSelect1 = 5'd5;
        ReadSelect2 = 5'd31;
        #1;
        check("rd_reg5", ReadData1, 64'h1122334455667788);
        check("rd_xzr", ReadData2, 64'd0);
        check_all_regs("rd_after_write");

        // Bypass
        RegWrite    = 1'b1;
        WriteSelect = 5'd7;
        WriteData   = 64'hABCD;
        ReadSelect1 = 5'd7;
        ReadSelect2 = 5'd7;
        #1;
        check("bypass_rd1", ReadData1, 64'hABCD);
        check("bypass_rd2", ReadData2, 64'hABCD);
        step();
        RegWrite = 1'b0;
        mregs[7] = 64'hABCD;
        #1;
        check("stored_rd1", ReadData1, 64'hABCD);
        check("stored_rd2", ReadData2, 64'hABCD);
        RegWrite    = 1'b1;
        WriteSelect = 5'd31;
        WriteData   = 64'h1234;
        ReadSelect1 = 5'd31;
        #1;
        check("bypass_xzr", ReadData1, 64'd0);
        step();
        RegWrite = 1'b0;

        // Full dump, no stalls
        for (int i = 0; i < 31; i++) wr(i, 64'(i * 'h100));
        DumpReady = 1'b1;
        load_exp_from_model();
        push_exp();
        pulse_req();
        check("start_valid", 64'(DumpValid), 64'd1);
        check("start_index", 64'(DumpIndex), 64'd0);
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            if (!DumpBusy) break;
            busy_cycles++;
            step();
        end
        check("busy_cycles", 64'(busy_cycles), 64'd32);
        check("full_dump_drained", 64'(sb.size()), 64'd0);

        // Stalled dump with a concurrent write, random stalls, and DumpReq held
        load_exp_from_model();
        push_exp();
        DumpReq = 1'b1;
        step();
        wait_index(5'd3, "reach_idx3");
        DumpReady = 1'b0;
        wr(3, 64'hDEAD);
        step();
        check("stall_index", 64'(DumpIndex), 64'd3);
        check("stall_data", DumpData, 64'h300);
        ReadSelect1 = 5'd3;
        #1;
        check("rd_during_dump", ReadData1, 64'hDEAD);
        DumpReady = 1'b1;
        step();
        check("after_stall_index", 64'(DumpIndex), 64'd4);
        for (int c = 0; c < 1000; c++) begin
            if (!DumpBusy) break;
            if (DumpIndex >= 5'd20) DumpReq = 1'b0;
            DumpReady = 1'($urandom_range(0, 1));
            step();
        end
        DumpReq   = 1'b0;
        DumpReady = 1'b1;
        wait_idle("stalled_dump_done");

        // Same-edge load write; the dump also confirms reg3=0xDEAD
        load_exp_from_model();
        exp_beats[10] = 64'h55;
        push_exp();
        pulse_req();
        wait_index(5'd9, "reach_idx9");
        RegWrite    = 1'b1;
        WriteSelect = 5'd10;
        WriteData   = 64'h55;
        step();
        RegWrite  = 1'b0;
        mregs[10] = 64'h55;
        check("same_edge_index", 64'(DumpIndex), 64'd10);
        check("same_edge_data", DumpData, 64'h55);
        wait_idle("same_edge_dump_done");

        // Reset mid-dump
        load_exp_from_model();
        push_exp();
        pulse_req();
        wait_index(5'd12, "reach_idx12");
        Reset_n   = 1'b0;
        DumpReady = 1'b0;
        step();
        check("midrst_valid", 64'(DumpValid), 64'd0);
        check("midrst_busy", 64'(DumpBusy), 64'd0);
        check("midrst_index", 64'(DumpIndex), 64'd0);
        check("midrst_data", DumpData, 64'd0);
        sb.delete();
        Reset_n = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        step();
        check("midrst_still_idle", 64'(DumpBusy), 64'd0);
        check_all_regs("rd_after_midrst");
        DumpReady = 1'b1;
        load_exp_from_model();
        push_exp();
        pulse_req();
        check("restart_index", 64'(DumpIndex), 64'd0);
        wait_idle("post_reset_dump_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
